// File: rtl/seg_scan_display_if.sv
// Bundle between the value-producing logic (master) and the seven-segment scanner (slave).
// Carries the display request inputs and the scanned anode/cathode outputs.
interface seg_scan_display_if #(
    parameter int unsigned NumDigits = 4,
    parameter int unsigned BrightW   = 3
);
    localparam int unsigned IdxW = (NumDigits > 1) ? $clog2(NumDigits) : 1;

    logic [4*NumDigits-1:0] value;
    logic [NumDigits-1:0]   dp_in;
    logic                   load;
    logic                   blank_lz;
    logic [BrightW-1:0]     brightness;
    logic [NumDigits-1:0]   an;
    logic [6:0]             sseg;
    logic                   dp;
    logic [IdxW-1:0]        digit_idx;
    logic                   frame_start;

    modport master (
        output value, dp_in, load, blank_lz, brightness,
        input  an, sseg, dp, digit_idx, frame_start
    );

    modport slave (
        input  value, dp_in, load, blank_lz, brightness,
        output an, sseg, dp, digit_idx, frame_start
    );
endinterface

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner: internal slot prescaler, frame-synchronous
// shadow loading, leading-zero blanking, PWM brightness and registered pin outputs.
module seg_scan_display #(
    parameter int unsigned NumDigits = 4,
    parameter int unsigned ScanDiv   = 100000,
    parameter int unsigned BrightW   = 3
) (
    input logic               clk_i,
    input logic               rst_ni,
    seg_scan_display_if.slave disp_io
);
    localparam int unsigned IdxW   = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam int unsigned CntW   = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
    localparam int unsigned SubLen = ScanDiv >> BrightW;
    localparam logic [CntW-1:0] CntMax = CntW'(ScanDiv - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(NumDigits - 1);

    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic                   frame_start_q, frame_start_d;
    logic [4*NumDigits-1:0] shadow_val_q, shadow_val_d;
    logic [NumDigits-1:0]   shadow_dp_q, shadow_dp_d;
    logic                   load_pend_q, load_pend_d;
    logic [NumDigits-1:0]   an_q, an_d;
    logic [6:0]             sseg_q, sseg_d;
    logic                   dp_q, dp_d;

    logic                   tick;
    logic                   boundary;
    logic [NumDigits-1:0]   blank;
    logic [CntW:0]          on_len;
    logic                   slot_on;
    logic [3:0]             cur_nib;

    function automatic logic [6:0] hex_to_sseg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Slot prescaler and digit sequencer
    always_comb begin
        tick          = (cnt_q == CntMax);
        boundary      = tick && (idx_q == IdxMax);
        cnt_d         = tick ? '0 : cnt_q + CntW'(1);
        idx_d         = idx_q;
        if (tick) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
        end
        frame_start_d = boundary;
    end

    // Shadow registers only move on a frame boundary so a frame is never torn.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        load_pend_d  = load_pend_q | disp_io.load;
        if (boundary && (load_pend_q || disp_io.load)) begin
            shadow_val_d = disp_io.value;
            shadow_dp_d  = disp_io.dp_in;
            load_pend_d  = 1'b0;
        end
    end

    // Walk from the most significant digit down; digit 0 is never blanked.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank    = '0;
        for (int k = NumDigits - 1; k >= 0; k--) begin
            zero_run = zero_run && (shadow_val_q[4*k +: 4] == 4'h0);
            blank[k] = disp_io.blank_lz && (k != 0) && zero_run;
        end
    end

    always_comb begin
        on_len  = (CntW + 1)'((32'(disp_io.brightness) + 32'd1) * SubLen);
        slot_on = ({1'b0, cnt_q} < on_len);
        cur_nib = shadow_val_q[4*idx_q +: 4];
        an_d    = '1;
        sseg_d  = 7'h7F;
        dp_d    = 1'b1;
        if (slot_on && !blank[idx_q]) begin
            an_d[idx_q] = 1'b0;
            sseg_d      = hex_to_sseg(cur_nib);
            dp_d        = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_start_q <= 1'b0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            load_pend_q   <= 1'b0;
            an_q          <= '1;
            sseg_q        <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_start_q <= frame_start_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            load_pend_q   <= load_pend_d;
            an_q          <= an_d;
            sseg_q        <= sseg_d;
            dp_q          <= dp_d;
        end
    end

    assign disp_io.an          = an_q;
    assign disp_io.sseg        = sseg_q;
    assign disp_io.dp          = dp_q;
    assign disp_io.digit_idx   = idx_q;
    assign disp_io.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with 4 digits, 8-cycle slots and 2-bit brightness.
module tb_seg_scan_display;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    seg_scan_display_if #(.NumDigits(4), .BrightW(2)) bus ();

    seg_scan_display #(
        .NumDigits(4),
        .ScanDiv  (8),
        .BrightW  (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .disp_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // seg holds {d3,d2,d1,d0} glyphs; dpn is the active-low dp expected per digit
    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic        blz;
        logic [1:0]  br;
        logic [27:0] seg;
        logic [3:0]  blank;
        logic [3:0]  dpn;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic wait_fs(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            seen = bus.frame_start;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Called at the negedge where frame_start is high; checks the whole next frame.
    task automatic check_frame(input logic [27:0] seg, input logic [3:0] blank,
                               input logic [3:0] dpn, input logic [1:0] br, input string tag);
        int s, p, on_len;
        logic lit;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic exp_dp;
        logic [1:0] exp_idx;
        on_len = (int'(br) + 1) * 2;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            s       = c / 8;
            p       = c % 8;
            lit     = (p < on_len) && !blank[s];
            exp_an  = lit ? ~(4'b0001 << s) : 4'hF;
            exp_seg = lit ? seg[7*s +: 7] : 7'h7F;
            exp_dp  = lit ? dpn[s] : 1'b1;
            exp_idx = 2'(((c + 1) / 8) % 4);
            chk($sformatf("%s c%0d an/sseg/dp/fs/idx", tag, c),
                32'({bus.an, bus.sseg, bus.dp, bus.frame_start, bus.digit_idx}),
                32'({exp_an, exp_seg, exp_dp, (c == 31), exp_idx}));
        end
    endtask

    task automatic pulse_load();
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        logic [27:0] old_seg;
        logic [6:0]  want;
        int          d;
        logic        seen;
        tests = 0;
        fails = 0;

        vecs[0]  = '{value:16'h12AF, dp_in:4'h0, blz:1'b0, br:2'd3,
                     seg:{7'h79, 7'h24, 7'h08, 7'h0E}, blank:4'b0000, dpn:4'hF};
        vecs[1]  = '{value:16'h0000, dp_in:4'h0, blz:1'b0, br:2'd3,
                     seg:{7'h40, 7'h40, 7'h40, 7'h40}, blank:4'b0000, dpn:4'hF};
        vecs[2]  = '{value:16'h0050, dp_in:4'h0, blz:1'b1, br:2'd3,
                     seg:{7'h7F, 7'h7F, 7'h12, 7'h40}, blank:4'b1100, dpn:4'hF};
        vecs[3]  = '{value:16'h0000, dp_in:4'h0, blz:1'b1, br:2'd3,
                     seg:{7'h7F, 7'h7F, 7'h7F, 7'h40}, blank:4'b1110, dpn:4'hF};
        vecs[4]  = '{value:16'h12AF, dp_in:4'h0, blz:1'b0, br:2'd0,
                     seg:{7'h79, 7'h24, 7'h08, 7'h0E}, blank:4'b0000, dpn:4'hF};
        vecs[5]  = '{value:16'h12AF, dp_in:4'h0, blz:1'b0, br:2'd2,
                     seg:{7'h79, 7'h24, 7'h08, 7'h0E}, blank:4'b0000, dpn:4'hF};
        vecs[6]  = '{value:16'h12AF, dp_in:4'b0100, blz:1'b0, br:2'd3,
                     seg:{7'h79, 7'h24, 7'h08, 7'h0E}, blank:4'b0000, dpn:4'b1011};
        vecs[7]  = '{value:16'h0003, dp_in:4'b1111, blz:1'b1, br:2'd3,
                     seg:{7'h7F, 7'h7F, 7'h7F, 7'h30}, blank:4'b1110, dpn:4'b1110};
        vecs[8]  = '{value:16'h89CE, dp_in:4'h0, blz:1'b0, br:2'd3,
                     seg:{7'h00, 7'h10, 7'h46, 7'h06}, blank:4'b0000, dpn:4'hF};
        vecs[9]  = '{value:16'h4567, dp_in:4'h0, blz:1'b0, br:2'd1,
                     seg:{7'h19, 7'h12, 7'h02, 7'h78}, blank:4'b0000, dpn:4'hF};
        vecs[10] = '{value:16'hD0B0, dp_in:4'b0101, blz:1'b1, br:2'd3,
                     seg:{7'h21, 7'h40, 7'h03, 7'h40}, blank:4'b0000, dpn:4'b1010};

        bus.value      = 16'h0;
        bus.dp_in      = 4'h0;
        bus.load       = 1'b0;
        bus.blank_lz   = 1'b0;
        bus.brightness = 2'd3;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (13) @(negedge clk);

        // Asynchronous reset in the middle of a slot
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset an/sseg/dp/idx/fs",
            32'({bus.an, bus.sseg, bus.dp, bus.digit_idx, bus.frame_start}),
            32'({4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}));
        @(negedge clk);
        chk("reset_held an", 32'(bus.an), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_release digit0", 32'({bus.an, bus.sseg, bus.digit_idx}),
            32'({4'b1110, 7'h40, 2'd0}));

        foreach (vecs[i]) begin
            bus.value      = vecs[i].value;
            bus.dp_in      = vecs[i].dp_in;
            bus.blank_lz   = vecs[i].blz;
            bus.brightness = vecs[i].br;
            pulse_load();
            wait_fs($sformatf("vec%0d wait_fs", i));
            check_frame(vecs[i].seg, vecs[i].blank, vecs[i].dpn, vecs[i].br,
                        $sformatf("vec%0d", i));
        end

        // Tear-free: a mid-frame load must not disturb digits already scheduled
        bus.value      = vecs[0].value;
        bus.dp_in      = 4'h0;
        bus.blank_lz   = 1'b0;
        bus.brightness = 2'd3;
        pulse_load();
        wait_fs("tear setup wait_fs");
        old_seg = vecs[0].seg;
        seen    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.digit_idx == 2'd1);
        end
        chk("tear reach idx1", 32'(seen), 32'd1);
        bus.value = 16'h0000;
        pulse_load();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.frame_start;
            if (bus.an != 4'hF) begin
                d = 0;
                for (int k = 0; k < 4; k++) if (!bus.an[k]) d = k;
                want = old_seg[7*d +: 7];
                chk($sformatf("tear old glyph d%0d", d), 32'(bus.sseg), 32'(want));
            end
        end
        chk("tear wait_fs", 32'(seen), 32'd1);
        check_frame(vecs[1].seg, vecs[1].blank, vecs[1].dpn, 2'd3, "tear_new");

        // Load asserted in the boundary tick cycle is captured at that boundary
        repeat (31) @(negedge clk);
        bus.value = 16'h4567;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        chk("coincident fs", 32'(bus.frame_start), 32'd1);
        check_frame(vecs[9].seg, 4'b0000, 4'hF, 2'd3, "coincident");

        // Without load the shadow value holds across frames
        bus.value = 16'hFFFF;
        check_frame(vecs[9].seg, 4'b0000, 4'hF, 2'd3, "hold");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
